// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC and the instruction-memory request FSM,
// and feeds instruction / sequential PC / write enable into the IF/ID register.
module fetch_stage #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_en,
    input  logic [15:0] redirect_PC,
    input  logic        halt,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_rdy,
    input  logic [15:0] imem_data,
    output logic [15:0] instruc_out,
    output logic [15:0] seq_PC_out,
    output logic        if_id_en
);

    typedef enum logic [2:0] {
        ST_ISSUE,
        ST_WAIT,
        ST_HOLD,
        ST_SQUASH,
        ST_HALT
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] hold_instr_q, hold_instr_d;

    logic        req_c;
    logic [15:0] instr_c;
    logic [15:0] seq_c;
    logic        en_c;
    logic [15:0] pc_plus2;

    assign pc_plus2 = pc_q + 16'd2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_ISSUE;
            pc_q         <= RESET_PC;
            hold_instr_q <= NOP_INSTR;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            hold_instr_q <= hold_instr_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        hold_instr_d = hold_instr_q;
        req_c        = 1'b0;
        instr_c      = NOP_INSTR;
        seq_c        = pc_q;
        en_c         = ~stall;

        if (state_q == ST_HALT) begin
            en_c = 1'b0;
        end else if (halt) begin
            state_d = ST_HALT;
            en_c    = 1'b1;
        end else if (redirect_en) begin
            // Flush beats stall; an unanswered request must still be drained.
            pc_d  = redirect_PC;
            seq_c = redirect_PC;
            en_c  = 1'b1;
            if ((state_q == ST_WAIT || state_q == ST_SQUASH) && !imem_rdy)
                state_d = ST_SQUASH;
            else
                state_d = ST_ISSUE;
        end else begin
            case (state_q)
                ST_ISSUE: begin
                    req_c   = 1'b1;
                    state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    if (imem_rdy && !stall) begin
                        instr_c = imem_data;
                        seq_c   = pc_plus2;
                        en_c    = 1'b1;
                        pc_d    = pc_plus2;
                        state_d = ST_ISSUE;
                    end else if (imem_rdy) begin
                        hold_instr_d = imem_data;
                        state_d      = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        instr_c = hold_instr_q;
                        seq_c   = pc_plus2;
                        en_c    = 1'b1;
                        pc_d    = pc_plus2;
                        state_d = ST_ISSUE;
                    end
                end
                ST_SQUASH: begin
                    if (imem_rdy)
                        state_d = ST_ISSUE;
                end
                default: begin
                    state_d = ST_ISSUE;
                end
            endcase
        end
    end

    // Outputs are forced quiet for as long as reset is held.
    always_comb begin
        imem_req    = rst ? 1'b0 : req_c;
        imem_addr   = rst ? RESET_PC : pc_q;
        instruc_out = rst ? NOP_INSTR : instr_c;
        seq_PC_out  = rst ? 16'h0000 : seq_c;
        if_id_en    = rst ? 1'b0 : en_c;
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table for the listed scenarios, then
// randomized traffic against a transaction-level reference model and memory.
module tb_fetch_stage;

    localparam logic [15:0] RST_PC = 16'h0000;
    localparam logic [15:0] NOP    = 16'h0800;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, redirect_en, halt, imem_rdy;
    logic [15:0] redirect_PC, imem_data;
    logic        imem_req, if_id_en;
    logic [15:0] imem_addr, instruc_out, seq_PC_out;

    fetch_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect_en(redirect_en),
        .redirect_PC(redirect_PC), .halt(halt), .imem_req(imem_req),
        .imem_addr(imem_addr), .imem_rdy(imem_rdy), .imem_data(imem_data),
        .instruc_out(instruc_out), .seq_PC_out(seq_PC_out), .if_id_en(if_id_en)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (vector %0d)", nm, act, exp, n_vec);
        end
    endtask

    task automatic check_outs(input logic e_rq, input logic [15:0] e_ad, input logic [15:0] e_in,
                              input logic [15:0] e_sq, input logic e_en);
        chk("imem_req", {15'b0, imem_req}, {15'b0, e_rq});
        chk("imem_addr", imem_addr, e_ad);
        chk("instruc_out", instruc_out, e_in);
        chk("seq_PC_out", seq_PC_out, e_sq);
        chk("if_id_en", {15'b0, if_id_en}, {15'b0, e_en});
        n_vec++;
    endtask

    typedef struct {
        logic        stl, rdr;
        logic [15:0] rpc;
        logic        hlt, rdy;
        logic [15:0] dat;
        logic        e_req;
        logic [15:0] e_addr, e_instr, e_seq;
        logic        e_en;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic stl, input logic rdr, input logic [15:0] rpc,
                               input logic hlt, input logic rdy, input logic [15:0] dat,
                               input logic e_req, input logic [15:0] e_addr,
                               input logic [15:0] e_instr, input logic [15:0] e_seq,
                               input logic e_en);
        vec_t r;
        r = '{stl, rdr, rpc, hlt, rdy, dat, e_req, e_addr, e_instr, e_seq, e_en};
        return r;
    endfunction

    // Reference model: what is outstanding and what is buffered, not FSM states.
    logic [15:0] m_pc, m_buf, n_pc, n_buf;
    logic        m_halted, m_inflight, m_squash, m_bufv;
    logic        n_halted, n_inflight, n_squash, n_bufv;
    logic        e_req, e_en;
    logic [15:0] e_addr, e_instr, e_seq;

    task automatic model_reset();
        m_pc = RST_PC; m_buf = NOP;
        m_halted = 0; m_inflight = 0; m_squash = 0; m_bufv = 0;
    endtask

    task automatic model_eval();
        logic [15:0] word;
        e_req = 0; e_addr = m_pc; e_instr = NOP; e_seq = m_pc; e_en = !stall;
        n_pc = m_pc; n_buf = m_buf; n_halted = m_halted;
        n_inflight = m_inflight; n_squash = m_squash; n_bufv = m_bufv;
        if (m_halted) begin
            e_en = 0;
        end else if (halt) begin
            e_en = 1; n_halted = 1; n_inflight = 0; n_squash = 0; n_bufv = 0;
        end else if (redirect_en) begin
            e_seq = redirect_PC; e_en = 1; n_pc = redirect_PC; n_bufv = 0;
            n_squash = (m_inflight || m_squash) && !imem_rdy;
            n_inflight = 0;
        end else if (m_bufv || (m_inflight && imem_rdy)) begin
            word = m_bufv ? m_buf : imem_data;
            if (!stall) begin
                e_instr = word; e_seq = m_pc + 16'd2; e_en = 1;
                n_pc = m_pc + 16'd2; n_bufv = 0; n_inflight = 0;
            end else begin
                n_buf = word; n_bufv = 1; n_inflight = 0;
            end
        end else if (m_squash) begin
            if (imem_rdy) n_squash = 0;
        end else if (!m_inflight) begin
            e_req = 1; n_inflight = 1;
        end
    endtask

    task automatic model_commit();
        m_pc = n_pc; m_buf = n_buf; m_halted = n_halted;
        m_inflight = n_inflight; m_squash = n_squash; m_bufv = n_bufv;
    endtask

    // Behavioural instruction memory with 1..3 cycle latency.
    logic        mem_busy;
    int          mem_cnt;
    logic [15:0] mem_dat;

    initial begin
        rst = 1; stall = 0; redirect_en = 0; redirect_PC = 0; halt = 0;
        imem_rdy = 0; imem_data = 0;
        #1;
        check_outs(0, RST_PC, NOP, 16'h0000, 0);

        tbl.push_back(v(0,0,16'h0000,0,0,16'h0000, 1,16'h0000,NOP,16'h0000,1));
        tbl.push_back(v(0,0,16'h0000,0,1,16'h4001, 0,16'h0000,16'h4001,16'h0002,1));
        tbl.push_back(v(0,0,16'h0000,0,0,16'h0000, 1,16'h0002,NOP,16'h0002,1));
        tbl.push_back(v(0,0,16'h0000,0,1,16'h4002, 0,16'h0002,16'h4002,16'h0004,1));
        tbl.push_back(v(0,0,16'h0000,0,0,16'h0000, 1,16'h0004,NOP,16'h0004,1));
        tbl.push_back(v(0,0,16'h0000,0,0,16'h0000, 0,16'h0004,NOP,16'h0004,1));
        tbl.push_back(v(0,0,16'h0000,0,0,16'h0000, 0,16'h0004,NOP,16'h0004,1));
        tbl.push_back(v(0,0,16'h0000,0,1,16'h1234, 0,16'h0004,16'h1234,16'h0006,1));
        tbl.push_back(v(1,0,16'h0000,0,0,16'h0000, 1,16'h0006,NOP,16'h0006,0));
        tbl.push_back(v(1,0,16'h0000,0,1,16'hC0DE, 0,16'h0006,NOP,16'h0006,0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(v(1,0,16'h0000,0,0,16'h0000, 0,16'h0006,NOP,16'h0006,0));
        tbl.push_back(v(0,0,16'h0000,0,0,16'h0000, 0,16'h0006,16'hC0DE,16'h0008,1));
        tbl.push_back(v(0,0,16'h0000,0,0,16'h0000, 1,16'h0008,NOP,16'h0008,1));
        tbl.push_back(v(0,1,16'h0100,0,0,16'h0000, 0,16'h0008,NOP,16'h0100,1));
        tbl.push_back(v(0,0,16'h0000,0,0,16'h0000, 0,16'h0100,NOP,16'h0100,1));
        tbl.push_back(v(0,0,16'h0000,0,1,16'hBAD0, 0,16'h0100,NOP,16'h0100,1));
        tbl.push_back(v(0,0,16'h0000,0,0,16'h0000, 1,16'h0100,NOP,16'h0100,1));
        tbl.push_back(v(1,0,16'h0000,0,1,16'h5555, 0,16'h0100,NOP,16'h0100,0));
        tbl.push_back(v(1,1,16'h0200,0,0,16'h0000, 0,16'h0100,NOP,16'h0200,1));
        tbl.push_back(v(0,0,16'h0000,0,0,16'h0000, 1,16'h0200,NOP,16'h0200,1));
        tbl.push_back(v(0,1,16'hFFFE,0,0,16'h0000, 0,16'h0200,NOP,16'hFFFE,1));
        tbl.push_back(v(1,1,16'hFFFE,0,0,16'h0000, 0,16'hFFFE,NOP,16'hFFFE,1));
        tbl.push_back(v(0,0,16'h0000,0,1,16'h0BAD, 0,16'hFFFE,NOP,16'hFFFE,1));
        tbl.push_back(v(0,0,16'h0000,0,0,16'h0000, 1,16'hFFFE,NOP,16'hFFFE,1));
        tbl.push_back(v(0,0,16'h0000,0,1,16'h7777, 0,16'hFFFE,16'h7777,16'h0000,1));
        tbl.push_back(v(0,0,16'h0000,0,0,16'h0000, 1,16'h0000,NOP,16'h0000,1));
        tbl.push_back(v(0,0,16'h0000,1,0,16'h0000, 0,16'h0000,NOP,16'h0000,1));
        tbl.push_back(v(0,1,16'h0300,0,1,16'h9999, 0,16'h0000,NOP,16'h0000,0));
        tbl.push_back(v(1,0,16'h0000,1,0,16'h0000, 0,16'h0000,NOP,16'h0000,0));
        tbl.push_back(v(0,0,16'h0000,0,0,16'h0000, 0,16'h0000,NOP,16'h0000,0));

        @(negedge clk);
        rst = 0;
        for (int i = 0; i < tbl.size(); i++) begin
            stall = tbl[i].stl; redirect_en = tbl[i].rdr; redirect_PC = tbl[i].rpc;
            halt = tbl[i].hlt; imem_rdy = tbl[i].rdy; imem_data = tbl[i].dat;
            #1;
            check_outs(tbl[i].e_req, tbl[i].e_addr, tbl[i].e_instr, tbl[i].e_seq, tbl[i].e_en);
            @(negedge clk);
        end

        // Short reset pulse between edges: state must clear without a clock.
        stall = 0; redirect_en = 0; halt = 0; imem_rdy = 0;
        rst = 1;
        #1 check_outs(0, RST_PC, NOP, 16'h0000, 0);
        #1 rst = 0;
        #1 check_outs(1, RST_PC, NOP, RST_PC, 1);
        rst = 1;
        @(negedge clk);

        model_reset();
        mem_busy = 0; mem_cnt = 0; mem_dat = 0;
        rst = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (($urandom_range(0, 149) == 0) || (m_halted && $urandom_range(0, 7) == 0)) begin
                rst = 1;
                #1 check_outs(0, RST_PC, NOP, 16'h0000, 0);
                model_reset();
                mem_busy = 0; mem_cnt = 0;
                @(negedge clk);
                rst = 0;
                continue;
            end
            stall       = ($urandom_range(0, 3) == 0);
            redirect_en = ($urandom_range(0, 11) == 0);
            redirect_PC = ($urandom_range(0, 7) == 0) ? 16'hFFFE : (16'($urandom) & 16'hFFFE);
            halt        = ($urandom_range(0, 199) == 0);
            imem_rdy    = mem_busy && (mem_cnt == 0);
            imem_data   = imem_rdy ? mem_dat : 16'($urandom);
            #1;
            model_eval();
            check_outs(e_req, e_addr, e_instr, e_seq, e_en);
            if (imem_req && mem_busy) begin
                n_err++;
                $display("FAIL one_outstanding: got req=1 with busy=1 expected req=0 (vector %0d)", n_vec);
            end
            @(posedge clk);
            model_commit();
            if (imem_rdy) mem_busy = 0;
            else if (mem_busy && mem_cnt > 0) mem_cnt--;
            if (imem_req) begin
                mem_busy = 1;
                mem_cnt  = $urandom_range(0, 2);
                mem_dat  = 16'($urandom);
            end
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
